// File: rtl/cbfp_exp_restore.sv
// cbfp_exp_restore: undoes per-group CBFP normalisation, bringing 16-lane complex beats back to one fixed-point scale.
// Optional build macro CBFP_EXP_STATS_EN adds sat_cnt / blk_cnt statistics outputs.
module cbfp_exp_restore #(
    parameter int cnt_size   = 5,
    parameter int array_size = 16,
    parameter int array_num  = 4,
    parameter int din_size   = 11,
    parameter int dout_size  = 16,
    parameter int exp_bias   = 5,
    parameter int blk_beats  = 4,
    parameter int exp_depth  = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              exp_valid,
    input  logic [cnt_size*array_num-1:0]     exp_in,
    output logic                              exp_ready,
    input  logic                              valid_in,
    input  logic [din_size*array_size-1:0]    din_re,
    input  logic [din_size*array_size-1:0]    din_im,
    output logic                              valid_out,
    output logic [dout_size*array_size-1:0]   dout_re,
    output logic [dout_size*array_size-1:0]   dout_im,
    output logic                              blk_last,
    output logic                              sat_flag,
    output logic                              err_udf,
    output logic                              err_ovf
`ifdef CBFP_EXP_STATS_EN
    ,
    output logic [15:0]                       sat_cnt,
    output logic [15:0]                       blk_cnt
`endif
);
    localparam int EW  = cnt_size * array_num;
    localparam int AW  = $clog2(exp_depth);
    localparam int BW  = (blk_beats > 1) ? $clog2(blk_beats) : 1;
    localparam int GL  = array_size / array_num;
    localparam int W   = dout_size + exp_bias;
    localparam int DIW = din_size * array_size;
    localparam int DOW = dout_size * array_size;
    localparam logic signed [W-1:0] SAT_HI = W'(2 ** (dout_size - 1) - 1);
    localparam logic signed [W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic {IDLE, RUN} state_t;

    logic [EW-1:0]   fifo_q [exp_depth];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     fill_q, fill_d;
    logic            fifo_empty, fifo_full, push, pop;
    state_t          state_q, state_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            accept, last_beat;
    logic            err_udf_q, err_ovf_q;
    logic            v1_q, last1_q;
    logic [DIW-1:0]  re1_q, im1_q;
    logic [EW-1:0]   exp1_q;
    logic [DOW-1:0]  re2_d, im2_d, dout_re_q, dout_im_q;
    logic [array_size-1:0] sat_re, sat_im;
    logic            valid_out_q, blk_last_q, sat_flag_q;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == (AW+1)'(exp_depth));
    // A pop frees the slot in the same cycle, so a push against a full FIFO still lands.
    assign push       = exp_valid && (!fifo_full || pop);
    assign exp_ready  = !fifo_full;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        accept     = 1'b0;
        last_beat  = 1'b0;
        pop        = 1'b0;
        if (valid_in && (state_q == RUN || !fifo_empty)) begin
            accept = 1'b1;
            if (beat_cnt_q == BW'(blk_beats - 1)) begin
                last_beat  = 1'b1;
                pop        = 1'b1;
                beat_cnt_d = '0;
                state_d    = IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + BW'(1);
                state_d    = RUN;
            end
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (push && !pop)      fill_d = fill_q + (AW+1)'(1);
        else if (pop && !push) fill_d = fill_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= exp_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            err_udf_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            fill_q     <= fill_d;
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            if (exp_valid && !push) err_ovf_q <= 1'b1;
            if (valid_in && state_q == IDLE && fifo_empty) err_udf_q <= 1'b1;
        end
    end

    // Stage 1: capture the beat together with the count set it belongs to.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            re1_q   <= '0;
            im1_q   <= '0;
            exp1_q  <= '0;
        end else begin
            v1_q    <= accept;
            last1_q <= last_beat;
            if (accept) begin
                re1_q  <= din_re;
                im1_q  <= din_im;
                exp1_q <= fifo_q[rd_ptr_q];
            end
        end
    end

    // Returns {clipped, value}; the right shift floors toward -inf.
    function automatic logic [dout_size:0] restore(input logic [din_size-1:0] d,
                                                   input logic [cnt_size-1:0] sh);
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        x = {{(W-din_size){d[din_size-1]}}, d};
        y = (x <<< exp_bias) >>> sh;
        if (y > SAT_HI) return {1'b1, SAT_HI[dout_size-1:0]};
        if (y < SAT_LO) return {1'b1, SAT_LO[dout_size-1:0]};
        return {1'b0, y[dout_size-1:0]};
    endfunction

    for (genvar gi = 0; gi < array_size; gi++) begin : g_lane
        logic [cnt_size-1:0] sh;
        assign sh = exp1_q[(gi / GL) * cnt_size +: cnt_size];
        assign {sat_re[gi], re2_d[gi*dout_size +: dout_size]} = restore(re1_q[gi*din_size +: din_size], sh);
        assign {sat_im[gi], im2_d[gi*dout_size +: dout_size]} = restore(im1_q[gi*din_size +: din_size], sh);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out_q <= 1'b0;
            blk_last_q  <= 1'b0;
            sat_flag_q  <= 1'b0;
            dout_re_q   <= '0;
            dout_im_q   <= '0;
        end else begin
            valid_out_q <= v1_q;
            blk_last_q  <= v1_q && last1_q;
            sat_flag_q  <= v1_q && ((|sat_re) || (|sat_im));
            if (v1_q) begin
                dout_re_q <= re2_d;
                dout_im_q <= im2_d;
            end
        end
    end

`ifdef CBFP_EXP_STATS_EN
    logic [15:0] sat_cnt_q, sat_cnt_d, blk_cnt_q;
    logic [16:0] sat_sum;

    assign sat_sum   = {1'b0, sat_cnt_q} + 17'($countones({sat_re, sat_im}));
    assign sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_cnt_q <= '0;
            blk_cnt_q <= '0;
        end else if (v1_q) begin
            sat_cnt_q <= sat_cnt_d;
            if (last1_q) blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
    assign blk_cnt = blk_cnt_q;
`endif

    assign valid_out = valid_out_q;
    assign blk_last  = blk_last_q;
    assign sat_flag  = sat_flag_q;
    assign dout_re   = dout_re_q;
    assign dout_im   = dout_im_q;
    assign err_udf   = err_udf_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_cbfp_exp_restore.sv
// Directed bench for cbfp_exp_restore: default instance (exp_bias 5) plus an exp_bias 6 instance for clipping.
module tb_cbfp_exp_restore;
    logic         clk = 1'b0;
    logic         rstn;
    logic         exp_valid;
    logic [19:0]  exp_in;
    logic         valid_in;
    logic [175:0] din_re, din_im;

    logic         exp_ready, valid_out, blk_last, sat_flag, err_udf, err_ovf;
    logic [255:0] dout_re, dout_im;
    logic         exp_ready6, valid_out6, blk_last6, sat_flag6, err_udf6, err_ovf6;
    logic [255:0] dout_re6, dout_im6;

    int errors = 0;
    int checks = 0;
    int er[4], ei[4], er6[4], ei6[4];
    logic esat, esat6;

    always #5 clk = ~clk;

    cbfp_exp_restore u_dut (
        .clk(clk), .rstn(rstn), .exp_valid(exp_valid), .exp_in(exp_in), .exp_ready(exp_ready),
        .valid_in(valid_in), .din_re(din_re), .din_im(din_im), .valid_out(valid_out),
        .dout_re(dout_re), .dout_im(dout_im), .blk_last(blk_last), .sat_flag(sat_flag),
        .err_udf(err_udf), .err_ovf(err_ovf)
    );

    cbfp_exp_restore #(.exp_bias(6)) u_dut6 (
        .clk(clk), .rstn(rstn), .exp_valid(exp_valid), .exp_in(exp_in), .exp_ready(exp_ready6),
        .valid_in(valid_in), .din_re(din_re), .din_im(din_im), .valid_out(valid_out6),
        .dout_re(dout_re6), .dout_im(dout_im6), .blk_last(blk_last6), .sat_flag(sat_flag6),
        .err_udf(err_udf6), .err_ovf(err_ovf6)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] epack(input int g0, input int g1, input int g2, input int g3);
        return {5'(g3), 5'(g2), 5'(g1), 5'(g0)};
    endfunction

    function automatic logic [175:0] ivec(input int val);
        logic [175:0] v;
        for (int i = 0; i < 16; i++) v[i*11 +: 11] = 11'(val);
        return v;
    endfunction

    function automatic logic [255:0] ovec(input int g[4]);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(g[i/4]);
        return v;
    endfunction

    task automatic push(input logic [19:0] e);
        exp_valid = 1'b1;
        exp_in    = e;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic set_uni(input int r, input int i, input int r6, input int i6);
        for (int g = 0; g < 4; g++) begin
            er[g] = r; ei[g] = i; er6[g] = r6; ei6[g] = i6;
        end
    endtask

    // Streams one 4-beat block back to back and checks each output beat two cycles later.
    task automatic run_block(input string tag, input int re, input int im);
        logic [255:0] xr, xi, xr6, xi6;
        xr = ovec(er); xi = ovec(ei); xr6 = ovec(er6); xi6 = ovec(ei6);
        din_re   = ivec(re);
        din_im   = ivec(im);
        valid_in = 1'b1;
        tick();
        chk({tag, ".lat1"}, valid_out, 1'b0);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) valid_in = 1'b0;
            tick();
            $display("%s beat %0d: valid=%0b last=%0b sat=%0b/%0b lane0 re=%0d im=%0d",
                     tag, b, valid_out, blk_last, sat_flag, sat_flag6,
                     $signed(dout_re[15:0]), $signed(dout_im[15:0]));
            chk($sformatf("%s.b%0d.vld", tag, b), valid_out, 1'b1);
            chk($sformatf("%s.b%0d.last", tag, b), blk_last, 1'(b == 3));
            chk($sformatf("%s.b%0d.sat", tag, b), sat_flag, esat);
            chk($sformatf("%s.b%0d.re", tag, b), dout_re, xr);
            chk($sformatf("%s.b%0d.im", tag, b), dout_im, xi);
            chk($sformatf("%s.b%0d.last6", tag, b), blk_last6, 1'(b == 3));
            chk($sformatf("%s.b%0d.sat6", tag, b), sat_flag6, esat6);
            chk($sformatf("%s.b%0d.re6", tag, b), dout_re6, xr6);
            chk($sformatf("%s.b%0d.im6", tag, b), dout_im6, xi6);
        end
        tick();
        chk({tag, ".idle_vld"}, valid_out, 1'b0);
        chk({tag, ".hold_re"}, dout_re, xr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; exp_valid = 1'b0; exp_in = '0; valid_in = 1'b0; din_re = '0; din_im = '0;
        repeat (2) tick();
        chk("rst.vld", valid_out, 1'b0);
        chk("rst.re", dout_re, '0);
        chk("rst.im", dout_im, '0);
        chk("rst.last", blk_last, 1'b0);
        chk("rst.sat", sat_flag, 1'b0);
        chk("rst.ready", exp_ready, 1'b1);
        chk("rst.udf", err_udf, 1'b0);
        chk("rst.ovf", err_ovf, 1'b0);
        chk("rst.ready6", exp_ready6, 1'b1);
        chk("rst.flags6", {err_udf6, err_ovf6, valid_out6}, 3'b000);
        rstn = 1'b1;
        tick();

        // 1: unit counts, bias 5 gives x32
        push(epack(0, 0, 0, 0));
        chk("t1.ready", exp_ready, 1'b1);
        set_uni(32, -32, 64, -64); esat = 1'b0; esat6 = 1'b0;
        run_block("t1", 1, -1);

        // 2: per-group counts with floor rounding
        push(epack(5, 6, 7, 0));
        er  = '{-3, -2, -1, -96};  ei  = '{3, 1, 0, 96};
        er6 = '{-6, -3, -2, -192}; ei6 = '{6, 3, 1, 192};
        run_block("t2", -3, 3);

        // 3: full-scale inputs; only the bias-6 instance clips
        push(epack(0, 0, 0, 0));
        set_uni(32736, -32768, 32767, -32768); esat = 1'b0; esat6 = 1'b1;
        run_block("t3", 1023, -1024);

        // 4: beat with empty FIFO; the count pushed in that same cycle is not usable yet
        chk("t4.udf_pre", err_udf, 1'b0);
        exp_valid = 1'b1; exp_in = epack(0, 0, 0, 0);
        valid_in = 1'b1; din_re = ivec(7); din_im = ivec(7);
        tick();
        exp_valid = 1'b0; valid_in = 1'b0;
        chk("t4.udf", err_udf, 1'b1);
        tick();
        chk("t4.drop1", valid_out, 1'b0);
        tick();
        chk("t4.drop2", valid_out, 1'b0);
        set_uni(64, 0, 128, 0); esat = 1'b0; esat6 = 1'b0;
        run_block("t4", 2, 0);
        chk("t4.udf_sticky", err_udf, 1'b1);

        // 5: overfill the count FIFO, then drain with four blocks
        for (int k = 0; k < 4; k++) push(epack(k, k, k, k));
        chk("t5.full", exp_ready, 1'b0);
        chk("t5.ovf_pre", err_ovf, 1'b0);
        push(epack(9, 9, 9, 9));
        chk("t5.ovf", err_ovf, 1'b1);
        for (int k = 0; k < 4; k++) begin
            set_uni(512 >> k, -(512 >> k), 1024 >> k, -(1024 >> k));
            run_block($sformatf("t5.k%0d", k), 16, -16);
            if (k == 0) chk("t5.ready_after_pop", exp_ready, 1'b1);
        end
        chk("t5.ovf_sticky", err_ovf, 1'b1);

        // 6: reset in the middle of a block with counts queued
        push(epack(0, 0, 0, 0));
        push(epack(0, 0, 0, 0));
        din_re = ivec(5); din_im = ivec(-5); valid_in = 1'b1;
        tick();
        tick();
        chk("t6.pre_vld", valid_out, 1'b1);
        rstn = 1'b0; valid_in = 1'b0;
        #2;
        chk("t6.rst.vld", valid_out, 1'b0);
        chk("t6.rst.re", dout_re, '0);
        chk("t6.rst.im", dout_im, '0);
        chk("t6.rst.last", blk_last, 1'b0);
        chk("t6.rst.udf", err_udf, 1'b0);
        chk("t6.rst.ovf", err_ovf, 1'b0);
        chk("t6.rst.ready", exp_ready, 1'b1);
        tick();
        rstn = 1'b1;
        tick();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("t6.empty_udf", err_udf, 1'b1);
        tick();
        chk("t6.drop1", valid_out, 1'b0);
        tick();
        chk("t6.drop2", valid_out, 1'b0);
        push(epack(1, 1, 1, 1));
        set_uni(80, -80, 160, -160); esat = 1'b0; esat6 = 1'b0;
        run_block("t6", 5, -5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
